// File: rtl/xmm_fixed_exec_if.sv
// Issue-side handshake and XMM register-file port bundle for the q15.48 execute unit.
// The slave modport is the execute unit's view; master is the issue logic plus register file.
interface xmm_fixed_exec_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [1:0]       op;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [4:0]       rf_read_addr1;
    logic [4:0]       rf_read_addr2;
    logic [WIDTH-1:0] rf_read_data1;
    logic [WIDTH-1:0] rf_read_data2;
    logic             rf_should_write;
    logic [4:0]       rf_write_addr;
    logic [WIDTH-1:0] rf_write_data;

    modport slave (
        input  start, op, rd, rs1, rs2, rf_read_data1, rf_read_data2,
        output busy, done, overflow, rf_read_addr1, rf_read_addr2,
        output rf_should_write, rf_write_addr, rf_write_data
    );

    modport master (
        output start, op, rd, rs1, rs2, rf_read_data1, rf_read_data2,
        input  busy, done, overflow, rf_read_addr1, rf_read_addr2,
        input  rf_should_write, rf_write_addr, rf_write_data
    );
endinterface

// File: rtl/xmm_fixed_exec.sv
// Multi-cycle saturating q15.48 execute unit (ADD/SUB/MUL/MIN) that reads two XMM
// registers and issues exactly one write-back per accepted request.
module xmm_fixed_exec #(
    parameter int WIDTH     = 64,
    parameter int FRAC_BITS = 48
) (
    input  logic             clk,
    input  logic             reset_n,
    xmm_fixed_exec_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, MUL, WRITE} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_MIN = 2'b11;

    localparam int PW   = 2 * WIDTH;
    localparam int TOP  = FRAC_BITS + WIDTH - 1;
    localparam int CW   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

    state_t           state_q;
    logic [1:0]       op_q;
    logic [4:0]       rd_q, rs1_q, rs2_q;
    logic             busy_q, done_q, ovf_q, we_q, neg_q;
    logic [WIDTH-1:0] wdata_q, mplier_q;
    logic [PW-1:0]    mcand_q, prod_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] opA, opB, magA, magB;
    logic [WIDTH:0]   addSum;
    logic [WIDTH-1:0] aluRes_d, mulRes_d, magOut;
    logic             aluOvf_d, mulOvf_d;
    logic [PW-1:0]    prod_d;

    assign opA = bus.rf_read_data1;
    assign opB = bus.rf_read_data2;

    always_comb begin
        magA     = opA[WIDTH-1] ? (~opA + 1'b1) : opA;
        magB     = opB[WIDTH-1] ? (~opB + 1'b1) : opB;
        addSum   = '0;
        aluRes_d = '0;
        aluOvf_d = 1'b0;
        case (op_q)
            OP_ADD:  addSum = {opA[WIDTH-1], opA} + {opB[WIDTH-1], opB};
            OP_SUB:  addSum = {opA[WIDTH-1], opA} - {opB[WIDTH-1], opB};
            default: addSum = '0;
        endcase
        // A 65-bit result whose top two bits disagree has left the 64-bit signed range.
        if (op_q == OP_MIN) begin
            aluRes_d = ($signed(opA) < $signed(opB)) ? opA : opB;
        end else if (addSum[WIDTH] != addSum[WIDTH-1]) begin
            aluOvf_d = 1'b1;
            aluRes_d = addSum[WIDTH] ? MIN_NEG : MAX_POS;
        end else begin
            aluRes_d = addSum[WIDTH-1:0];
        end
    end

    always_comb begin
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        magOut   = prod_d[TOP:FRAC_BITS];
        mulRes_d = '0;
        mulOvf_d = 1'b0;
        // Magnitude 2^63 is representable only as the most negative value.
        if (prod_d[PW-1:TOP] != '0) begin
            if (neg_q && prod_d[PW-1:TOP+1] == '0 && magOut == MIN_NEG) begin
                mulRes_d = MIN_NEG;
            end else begin
                mulOvf_d = 1'b1;
                mulRes_d = neg_q ? MIN_NEG : MAX_POS;
            end
        end else begin
            mulRes_d = neg_q ? (~magOut + 1'b1) : magOut;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            we_q     <= 1'b0;
            neg_q    <= 1'b0;
            wdata_q  <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        rd_q    <= bus.rd;
                        rs1_q   <= bus.rs1;
                        rs2_q   <= bus.rs2;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (op_q == OP_MUL) begin
                        mcand_q  <= {{WIDTH{1'b0}}, magA};
                        mplier_q <= magB;
                        prod_q   <= '0;
                        neg_q    <= opA[WIDTH-1] ^ opB[WIDTH-1];
                        cnt_q    <= '0;
                        state_q  <= MUL;
                    end else begin
                        wdata_q <= aluRes_d;
                        ovf_q   <= aluOvf_d;
                        done_q  <= 1'b1;
                        we_q    <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                MUL: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        wdata_q <= mulRes_d;
                        ovf_q   <= mulOvf_d;
                        done_q  <= 1'b1;
                        we_q    <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    done_q  <= 1'b0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.overflow        = ovf_q;
    assign bus.rf_read_addr1   = rs1_q;
    assign bus.rf_read_addr2   = rs2_q;
    assign bus.rf_should_write = we_q;
    assign bus.rf_write_addr   = rd_q;
    assign bus.rf_write_data   = wdata_q;
endmodule
